// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetches one instruction word at a time from instruction memory, holds it
//   for the control unit until accepted, then waits for the control unit's
//   PC-select word to form the next PC. A misaligned target halts the unit
//   with a sticky fault until reset.
//
// Ports
//   clk, rst           system clock; synchronous active-high reset
//   imem_req/addr      memory read request and byte address (addr = pc)
//   imem_ack/data      memory data-valid strobe and returned word
//   instr/instr_valid  held instruction and its valid flag
//   instr_ready        control unit accepts instr
//   pc                 address of the instruction currently held
//   ps/ps_valid        PC select (00 same, 01 +4, 10 +br_off*4, 11 jump_addr)
//   br_off, jump_addr  branch word offset (signed) and register jump target
//   fault              sticky misaligned-target flag
//   fetch_cnt          count of accepted instructions (wraps)
//
// States
//   FETCH | request issued for pc, ack may already arrive this cycle
//   WAIT  | request held until memory acks
//   HOLD  | instr presented, waiting for instr_ready
//   NEXT  | waiting for ps_valid to select the next pc
//   HALT  | misaligned target seen; idle until reset
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [63:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_data,
    output logic [31:0]      instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [63:0]      pc,
    input  logic [1:0]       ps,
    input  logic             ps_valid,
    input  logic [63:0]      br_off,
    input  logic [63:0]      jump_addr,
    output logic             fault,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        WAIT  = 3'd1,
        HOLD  = 3'd2,
        NEXT  = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] next_pc;
    logic        ld_instr;
    logic        ld_pc;
    logic        set_fault;
    logic        inc_cnt;

    always_comb begin
        case (ps)
            2'b00:   next_pc = pc;
            2'b01:   next_pc = pc + 64'd4;
            2'b10:   next_pc = pc + (br_off << 2);
            default: next_pc = jump_addr;
        endcase
    end

    always_comb begin
        state_nxt = state;
        ld_instr  = 1'b0;
        ld_pc     = 1'b0;
        set_fault = 1'b0;
        inc_cnt   = 1'b0;
        case (state)
            FETCH, WAIT: begin
                if (imem_ack) begin
                    ld_instr  = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    state_nxt = WAIT;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    inc_cnt   = 1'b1;
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (ps_valid) begin
                    // pc is left untouched on a misaligned target so the
                    // faulting instruction's address stays visible.
                    if (next_pc[1:0] != 2'b00) begin
                        set_fault = 1'b1;
                        state_nxt = HALT;
                    end else begin
                        ld_pc     = 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            instr     <= 32'd0;
            fault     <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (ld_instr)  instr     <= imem_data;
            if (ld_pc)     pc        <= next_pc;
            if (set_fault) fault     <= 1'b1;
            if (inc_cnt)   fetch_cnt <= fetch_cnt + CNT_W'(1);
        end
    end

    // Gating with rst keeps the request low for the whole time reset is held,
    // even though the state register already sits in FETCH after the first
    // reset edge.
    assign imem_req    = ((state == FETCH) || (state == WAIT)) && !rst;
    assign imem_addr   = pc;
    assign instr_valid = (state == HOLD);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Scoreboard bench: the driver pushes the (pc, word) it expects to see
//   presented whenever it starts a fetch; an independent monitor pops and
//   compares on every accepted instruction. A behavioural memory answers
//   requests after a programmable number of wait cycles and throws random
//   acks when no request is pending.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int          CNT_W    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             imem_req;
    logic [63:0]      imem_addr;
    logic             imem_ack = 1'b0;
    logic [31:0]      imem_data = 32'd0;
    logic [31:0]      instr;
    logic             instr_valid;
    logic             instr_ready = 1'b0;
    logic [63:0]      pc;
    logic [1:0]       ps = 2'b00;
    logic             ps_valid = 1'b0;
    logic [63:0]      br_off = 64'd0;
    logic [63:0]      jump_addr = 64'd0;
    logic             fault;
    logic [CNT_W-1:0] fetch_cnt;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc(pc), .ps(ps), .ps_valid(ps_valid),
        .br_off(br_off), .jump_addr(jump_addr),
        .fault(fault), .fetch_cnt(fetch_cnt)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] model_pc = RESET_PC;

    // memory control
    logic        mem_auto   = 1'b0;
    logic        man_ack    = 1'b0;
    logic [31:0] man_data   = 32'd0;
    int          next_delay = 0;
    int          cur_delay  = 0;
    int          req_age    = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: event did not occur as required at %0t", name, $time);
    endtask

    // Behavioural memory: acks after cur_delay extra request cycles, noise otherwise.
    always begin
        @(negedge clk);
        #1;
        imem_ack  = 1'b0;
        imem_data = $urandom();
        if (!mem_auto) begin
            imem_ack  = man_ack;
            imem_data = man_data;
            req_age   = 0;
        end else if (imem_req) begin
            if (req_age == 0) cur_delay = next_delay;
            if (req_age == cur_delay) begin
                imem_ack  = 1'b1;
                imem_data = mem_word(imem_addr);
                req_age   = 0;
            end else begin
                req_age++;
            end
        end else begin
            req_age  = 0;
            imem_ack = 1'($urandom);
        end
    end

    // Monitor / scoreboard
    int          model_cnt = 0;
    logic        held = 1'b0;
    logic [31:0] held_instr;
    logic [63:0] held_pc;

    always begin
        exp_t e;
        @(negedge clk);
        #1;
        check("req_and_valid_exclusive", 64'(imem_req && instr_valid), 64'd0);
        if (rst) begin
            sb_q.delete();
            model_cnt = 0;
            held      = 1'b0;
        end else begin
            if (held && instr_valid) begin
                check("hold_instr_stable", 64'(instr), 64'(held_instr));
                check("hold_pc_stable", pc, held_pc);
                check("hold_cnt_stable", 64'(fetch_cnt), 64'(model_cnt));
            end
            if (instr_valid && instr_ready) begin
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_instr");
                end else begin
                    e = sb_q.pop_front();
                    check("sb_pc", pc, e.pc);
                    check("sb_instr", 64'(instr), 64'(e.word));
                    check("sb_fetch_cnt", 64'(fetch_cnt), 64'(model_cnt));
                end
                model_cnt = (model_cnt + 1) % (1 << CNT_W);
                held      = 1'b0;
            end else if (instr_valid) begin
                held       = 1'b1;
                held_instr = instr;
                held_pc    = pc;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic junk();
        ps        = 2'($urandom);
        ps_valid  = 1'($urandom);
        br_off    = {$urandom(), $urandom()};
        jump_addr = {$urandom(), $urandom()};
    endtask

    // Called at a negedge with the DUT in FETCH; returns at the negedge after
    // the control word has been consumed.
    task automatic one_instr(input logic [1:0] p, input logic [63:0] off, input logic [63:0] ja,
                             input int dly, input int hold, input int gap,
                             output logic [63:0] addr_seen, output logic [63:0] cnt0);
        int          req_cycles;
        int          budget;
        logic [63:0] nxt;
        next_delay = dly;
        req_cycles = 0;
        budget     = 0;
        addr_seen  = 64'd0;
        cnt0       = 64'd0;
        forever begin
            junk();
            instr_ready = 1'b0;
            #1;
            if (budget == 0) cnt0 = 64'(fetch_cnt);
            if (instr_valid) break;
            if (imem_req) begin
                if (req_cycles == 0) addr_seen = imem_addr;
                check("imem_addr", imem_addr, model_pc);
                req_cycles++;
            end
            budget++;
            if (budget > 60) begin
                fail_now("fetch_timeout");
                return;
            end
            @(negedge clk);
        end
        check("req_cycles", 64'(req_cycles), 64'(dly + 1));
        repeat (hold) begin
            @(negedge clk);
            junk();
            instr_ready = 1'b0;
        end
        @(negedge clk);
        junk();
        instr_ready = 1'b1;
        #1 check("valid_at_accept", 64'(instr_valid), 64'd1);
        @(negedge clk);
        instr_ready = 1'b0;
        for (int g = 0; g < gap; g++) begin
            junk();
            ps_valid = 1'b0;
            @(negedge clk);
        end
        ps        = p;
        br_off    = off;
        jump_addr = ja;
        ps_valid  = 1'b1;
        case (p)
            2'b00:   nxt = model_pc;
            2'b01:   nxt = model_pc + 64'd4;
            2'b10:   nxt = model_pc + off * 64'd4;
            default: nxt = ja;
        endcase
        if (nxt % 64'd4 == 64'd0) begin
            model_pc = nxt;
            sb_q.push_back('{nxt, mem_word(nxt)});
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input bit late_ack);
        @(negedge clk);
        rst         = 1'b1;
        mem_auto    = 1'b0;
        man_ack     = 1'b0;
        instr_ready = 1'b0;
        junk();
        #1 check("req_low_in_rst", 64'(imem_req), 64'd0);
        @(negedge clk);
        if (late_ack) begin
            man_ack  = 1'b1;
            man_data = 32'hDEAD_BEEF;
        end
        junk();
        #1;
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_pc", pc, RESET_PC);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_fetch_cnt", 64'(fetch_cnt), 64'd0);
        @(negedge clk);
        rst      = 1'b0;
        man_ack  = 1'b0;
        mem_auto = 1'b1;
        model_pc = RESET_PC;
        sb_q.push_back('{RESET_PC, mem_word(RESET_PC)});
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] c;

        do_reset(1'b0);

        // sequential fetch, wait states, backpressure
        one_instr(2'b01, 64'd0, 64'd0, 0, 0, 0, a, c);
        check("seq_addr_0", a, 64'h0);
        one_instr(2'b01, 64'd0, 64'd0, 0, 0, 0, a, c);
        check("seq_addr_4", a, 64'h4);
        one_instr(2'b01, 64'd0, 64'd0, 3, 0, 0, a, c);
        check("seq_addr_8", a, 64'h8);
        one_instr(2'b01, 64'd0, 64'd0, 0, 5, 0, a, c);
        check("seq_addr_c", a, 64'hC);

        // branch back by two words, then register jump, then refetch
        one_instr(2'b10, -64'sd2, 64'd0, 0, 0, 1, a, c);
        check("cnt_after_4", c, 64'd4);
        check("addr_0x10", a, 64'h10);
        one_instr(2'b11, 64'd0, 64'h100, 1, 0, 0, a, c);
        check("branch_target", a, 64'h8);
        one_instr(2'b00, 64'd0, 64'd0, 0, 1, 0, a, c);
        check("jump_target", a, 64'h100);
        one_instr(2'b01, 64'd0, 64'd0, 2, 0, 0, a, c);
        check("refetch_addr", a, 64'h100);

        for (int i = 0; i < 40; i++) begin
            int          so;
            logic [1:0]  p;
            logic [63:0] ja;
            p  = 2'($urandom);
            so = int'($urandom_range(0, 255)) - 128;
            ja = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                             : ({$urandom(), $urandom()} & ~64'h3);
            one_instr(p, 64'(so), ja, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 2), a, c);
        end

        // misaligned jump halts with fault
        one_instr(2'b11, 64'd0, 64'h102, 0, 0, 0, a, c);
        #1;
        check("fault_set", 64'(fault), 64'd1);
        check("fault_pc_kept", pc, model_pc);
        repeat (10) begin
            @(negedge clk);
            junk();
            #1;
            check("halt_no_req", 64'(imem_req), 64'd0);
            check("halt_no_valid", 64'(instr_valid), 64'd0);
        end
        do_reset(1'b0);
        one_instr(2'b01, 64'd0, 64'd0, 0, 0, 0, a, c);
        check("post_fault_addr", a, RESET_PC);

        // reset in the middle of a slow fetch, late ack during reset
        next_delay = 20;
        junk();
        #1 check("midwait_req_fetch", 64'(imem_req), 64'd1);
        @(negedge clk);
        junk();
        #1 check("midwait_req_wait", 64'(imem_req), 64'd1);
        do_reset(1'b1);

        // counter wrap (CNT_W = 3)
        for (int i = 0; i < 9; i++) begin
            one_instr(2'b01, 64'd0, 64'd0, $urandom_range(0, 1), 0, 0, a, c);
            if (i == 0) check("post_rst_addr", a, RESET_PC);
            if (i == 7) check("cnt_before_wrap", c, 64'd7);
            if (i == 8) check("cnt_wrapped", c, 64'd0);
        end
        check("sb_pending", 64'(sb_q.size()), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
